imem_access_ctrl: RTL and testbench

- Owns the single read/byte-write port of the instruction memory (byte array, big-endian 4-byte read word).
- After reset it holds the core while a byte-serial loader streams a program image into memory from address 0, then releases the core.
- In run mode it arbitrates the memory read port between the IF stage (fetch) and a debug word-read port, with a starvation guard. Sits between IF stage, loader/UART bridge and the memory array.

---
 rtl/imem_access_ctrl_pkg.sv | 21 ++
 rtl/imem_access_ctrl_rd_arbiter.sv | 41 ++++
 rtl/imem_access_ctrl.sv | 139 +++++++++++++
 tb/tb_imem_access_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_access_ctrl_pkg.sv
// Shared types and constants for the instruction-memory access controller.
// Holds the controller state encoding, the fault/NOP word and default geometry.
package imem_access_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } imem_state_e;

  localparam logic [31:0] NOP_WORD         = 32'h0;
  localparam int          MEM_BYTES_DEF    = 72;
  localparam int          ADDR_W_DEF       = 7;
  localparam int          STARVE_LIMIT_DEF = 4;

  // A 4-byte word starting at addr lies entirely inside a mem_bytes array.
  function automatic logic word_in_range(input logic [31:0] addr, input int mem_bytes);
    return addr <= 32'(mem_bytes - 4);
  endfunction

endpackage

// File: rtl/imem_access_ctrl_rd_arbiter.sv
// Fetch/debug read-port arbiter: combinational grants, fetch-first with a starvation guard.
// A pending debug request that loses STARVE_LIMIT times in a row wins the following cycle.
module imem_rd_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic fetch_req_i,
  input  logic dbg_req_i,
  output logic fetch_gnt_o,
  output logic dbg_gnt_o
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_cnt_q;
  logic [CNT_W-1:0] starve_cnt_d;
  logic             starve_hit;

  assign starve_hit  = (starve_cnt_q == CNT_W'(STARVE_LIMIT));
  assign dbg_gnt_o   = en_i && dbg_req_i && (!fetch_req_i || starve_hit);
  assign fetch_gnt_o = en_i && fetch_req_i && !dbg_gnt_o;

  // Count only cycles where debug is waiting and fetch took the port.
  always_comb begin
    starve_cnt_d = '0;
    if (en_i && dbg_req_i && fetch_gnt_o) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/imem_access_ctrl.sv
// Instruction-memory port owner: boot-time byte loader, then fetch/debug read arbitration.
// Reads return one cycle after grant; loader is throttled only by ld_ready (high throughout LOAD).
module imem_access_ctrl
  import imem_access_ctrl_pkg::*;
#(
  parameter int MEM_BYTES    = MEM_BYTES_DEF,
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid,
  input  logic [7:0]        ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  input  logic              reload,
  output logic              core_hold,
  output logic              load_ovf,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_addr,
  output logic              fetch_gnt,
  output logic [31:0]       inst_out,
  output logic              inst_valid,
  output logic              fetch_fault,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_ack,
  output logic [31:0]       dbg_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [31:0]       mem_rdata
);

  imem_state_e       state_q;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] wr_ptr_d;

  logic in_load;
  logic arb_en;
  logic ld_acc;
  logic ld_full;
  logic fetch_win;
  logic dbg_win;
  logic fetch_bad;
  logic dbg_ok;

  assign in_load = (state_q == ST_LOAD);
  assign arb_en  = (state_q == ST_RUN) && !reload;

  // wr_ptr parks at MEM_BYTES once full (MEM_BYTES must be below 2**ADDR_W).
  assign ld_ready  = in_load && !reload;
  assign ld_acc    = ld_valid && ld_ready;
  assign ld_full   = (wr_ptr_q == ADDR_W'(MEM_BYTES));
  assign mem_we    = ld_acc && !ld_full;
  assign mem_wdata = ld_data;
  assign wr_ptr_d  = mem_we ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;

  assign fetch_bad = (fetch_addr[1:0] != 2'b00) || !word_in_range(fetch_addr, MEM_BYTES);
  assign dbg_ok    = word_in_range(32'(dbg_addr), MEM_BYTES);

  imem_rd_arbiter #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_arb (
    .clk         (clk),
    .rst         (rst),
    .en_i        (arb_en),
    .fetch_req_i (fetch_req),
    .dbg_req_i   (dbg_req),
    .fetch_gnt_o (fetch_win),
    .dbg_gnt_o   (dbg_win)
  );

  assign fetch_gnt = fetch_win;

  always_comb begin
    mem_addr = fetch_addr[ADDR_W-1:0];
    if (in_load) begin
      mem_addr = wr_ptr_q;
    end else if (dbg_win) begin
      mem_addr = dbg_addr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_BOOT;
      wr_ptr_q    <= '0;
      core_hold   <= 1'b1;
      load_ovf    <= 1'b0;
      inst_out    <= NOP_WORD;
      inst_valid  <= 1'b0;
      fetch_fault <= 1'b0;
      dbg_ack     <= 1'b0;
      dbg_rdata   <= NOP_WORD;
    end else begin
      inst_valid  <= fetch_win;
      fetch_fault <= fetch_win && fetch_bad;
      dbg_ack     <= dbg_win;
      if (fetch_win) begin
        inst_out <= fetch_bad ? NOP_WORD : mem_rdata;
      end
      if (dbg_win) begin
        dbg_rdata <= dbg_ok ? mem_rdata : NOP_WORD;
      end

      unique case (state_q)
        ST_BOOT: begin
          state_q <= ST_LOAD;
        end
        ST_LOAD: begin
          wr_ptr_q <= wr_ptr_d;
          if (ld_acc && ld_full) begin
            load_ovf <= 1'b1;
          end
          if (ld_acc && ld_last) begin
            state_q   <= ST_RUN;
            core_hold <= 1'b0;
          end
        end
        ST_RUN: begin
          state_q <= ST_RUN;
        end
        default: begin
          state_q <= ST_BOOT;
        end
      endcase

      // Reload overrides everything: rewind the loader and re-hold the core.
      if (reload) begin
        state_q   <= ST_BOOT;
        wr_ptr_q  <= '0;
        load_ovf  <= 1'b0;
        core_hold <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_imem_access_ctrl.sv
// Directed + randomized bench for imem_access_ctrl; the bench owns the memory array.
module tb_imem_access_ctrl;

  localparam int MEM_BYTES    = 72;
  localparam int ADDR_W       = 7;
  localparam int STARVE_LIMIT = 4;
  localparam logic [7:0] FILL = 8'hA5;

  logic              clk;
  logic              rst;
  logic              ld_valid;
  logic [7:0]        ld_data;
  logic              ld_last;
  logic              ld_ready;
  logic              reload;
  logic              core_hold;
  logic              load_ovf;
  logic              fetch_req;
  logic [31:0]       fetch_addr;
  logic              fetch_gnt;
  logic [31:0]       inst_out;
  logic              inst_valid;
  logic              fetch_fault;
  logic              dbg_req;
  logic [ADDR_W-1:0] dbg_addr;
  logic              dbg_ack;
  logic [31:0]       dbg_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic [31:0]       mem_rdata;

  int vectors;
  int miscompares;

  // Physical memory the DUT drives, and the bench's own expectation of its contents.
  logic [7:0] tbmem [0:131] = '{default: 8'hA5};
  logic [7:0] ref_mem [0:131];
  logic [7:0] img [$];

  imem_access_ctrl #(
    .MEM_BYTES    (MEM_BYTES),
    .ADDR_W       (ADDR_W),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ld_valid    (ld_valid),
    .ld_data     (ld_data),
    .ld_last     (ld_last),
    .ld_ready    (ld_ready),
    .reload      (reload),
    .core_hold   (core_hold),
    .load_ovf    (load_ovf),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_gnt   (fetch_gnt),
    .inst_out    (inst_out),
    .inst_valid  (inst_valid),
    .fetch_fault (fetch_fault),
    .dbg_req     (dbg_req),
    .dbg_addr    (dbg_addr),
    .dbg_ack     (dbg_ack),
    .dbg_rdata   (dbg_rdata),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) tbmem[int'(mem_addr)] <= mem_wdata;
  end

  always_comb begin
    mem_rdata = {tbmem[int'(mem_addr)], tbmem[int'(mem_addr) + 1],
                 tbmem[int'(mem_addr) + 2], tbmem[int'(mem_addr) + 3]};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] word_at(input int a);
    return {ref_mem[a], ref_mem[a + 1], ref_mem[a + 2], ref_mem[a + 3]};
  endfunction

  function automatic logic in_range(input logic [31:0] a);
    return ({32'b0, a} + 64'd4) <= 64'(MEM_BYTES);
  endfunction

  task automatic wait_ready();
    for (int k = 0; k < 8 && !ld_ready; k++) tick();
    chk("ld_ready_wait", ld_ready, 1);
  endtask

  task automatic load_image(input int n, input bit with_last);
    wait_ready();
    for (int i = 0; i < n; i++) begin
      ld_valid = 1'b1;
      ld_data  = img[i];
      ld_last  = with_last && (i == n - 1);
      #1;
      chk("load_ready", ld_ready, 1);
      chk("load_hold", core_hold, 1);
      chk("load_we", mem_we, (i < MEM_BYTES));
      if (i < MEM_BYTES) begin
        chk("load_addr", mem_addr, i);
        chk("load_wdata", mem_wdata, img[i]);
        ref_mem[i] = img[i];
      end
      if (i == MEM_BYTES) chk("ovf_before", load_ovf, 0);
      tick();
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic rand_image(input int n);
    img = {};
    for (int i = 0; i < n; i++) img.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic do_fetch(input logic [31:0] a);
    logic        exp_fault;
    logic [31:0] exp_inst;
    exp_fault  = (a % 4 != 0) || !in_range(a);
    exp_inst   = exp_fault ? 32'h0 : word_at(int'(a));
    fetch_req  = 1'b1;
    fetch_addr = a;
    #1;
    chk("fetch_gnt", fetch_gnt, 1);
    tick();
    fetch_req = 1'b0;
    chk("fetch_valid", inst_valid, 1);
    chk("fetch_fault", fetch_fault, exp_fault);
    chk("fetch_inst", inst_out, exp_inst);
  endtask

  task automatic do_dbg(input logic [ADDR_W-1:0] a);
    logic [31:0] exp_d;
    exp_d    = in_range(32'(a)) ? word_at(int'(a)) : 32'h0;
    dbg_req  = 1'b1;
    dbg_addr = a;
    #1;
    chk("dbg_mem_addr", mem_addr, a);
    tick();
    chk("dbg_ack", dbg_ack, 1);
    chk("dbg_rdata", dbg_rdata, exp_d);
    dbg_req = 1'b0;
    tick();
    chk("dbg_ack_drop", dbg_ack, 0);
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    #1;
    chk("reload_no_ready", ld_ready, 0);
    tick();
    reload = 1'b0;
    chk("reload_hold", core_hold, 1);
    chk("reload_ovf_clr", load_ovf, 0);
  endtask

  initial begin
    int ack_at;
    int acks;
    vectors     = 0;
    miscompares = 0;
    for (int i = 0; i < 132; i++) ref_mem[i] = FILL;
    rst = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0; reload = 1'b0;
    fetch_req = 1'b0; fetch_addr = '0; dbg_req = 1'b0; dbg_addr = '0;

    #7;
    chk("rst_hold", core_hold, 1);
    chk("rst_ovf", load_ovf, 0);
    chk("rst_ready", ld_ready, 0);
    chk("rst_inst", inst_out, 0);
    chk("rst_ivalid", inst_valid, 0);
    chk("rst_fault", fetch_fault, 0);
    chk("rst_ack", dbg_ack, 0);
    chk("rst_rdata", dbg_rdata, 0);
    chk("rst_we", mem_we, 0);
    #5 rst = 1'b1;

    // Known program image, then fetch the second word.
    img = {8'hE3, 8'hA0, 8'h00, 8'h14, 8'hE3, 8'hA0, 8'h1A, 8'h01};
    load_image(8, 1'b1);
    chk("run_hold", core_hold, 0);
    chk("run_ready", ld_ready, 0);
    do_fetch(32'd4);
    chk("fetch4_const", inst_out, 32'hE3A01A01);
    do_fetch(32'd0);
    chk("fetch0_const", inst_out, 32'hE3A00014);

    // Reload while a fetch result is in flight.
    fetch_req = 1'b1; fetch_addr = 32'd4;
    tick();
    reload = 1'b1; fetch_req = 1'b1;
    #1;
    chk("reload_no_gnt", fetch_gnt, 0);
    chk("inflight_valid", inst_valid, 1);
    chk("inflight_inst", inst_out, 32'hE3A01A01);
    tick();
    reload = 1'b0; fetch_req = 1'b0;
    chk("reload_hold_next", core_hold, 1);
    chk("reload_ivalid", inst_valid, 0);
    rand_image(4);
    load_image(4, 1'b1);
    chk("reload_run_hold", core_hold, 0);
    do_fetch(32'd0);

    // Overflowing image: 73 bytes with no terminator, then a dropped terminating byte.
    pulse_reload();
    rand_image(MEM_BYTES + 1);
    load_image(MEM_BYTES + 1, 1'b0);
    chk("ovf_set", load_ovf, 1);
    chk("ovf_ready", ld_ready, 1);
    chk("ovf_byte72", tbmem[MEM_BYTES], FILL);
    ld_valid = 1'b1; ld_last = 1'b1; ld_data = 8'h3C;
    #1;
    chk("ovf_last_we", mem_we, 0);
    tick();
    ld_valid = 1'b0; ld_last = 1'b0;
    chk("ovf_run_hold", core_hold, 0);
    chk("ovf_sticky", load_ovf, 1);

    do_fetch(32'd2);
    do_fetch(32'd70);
    do_fetch(32'd68);
    do_fetch(32'd72);
    do_fetch(32'hFFFF_FFFC);
    do_fetch(32'h0000_0100);
    for (int i = 0; i < 24; i++) do_fetch(32'($urandom_range(0, 17)) * 4);
    for (int i = 0; i < 12; i++) do_fetch(32'($urandom_range(0, 90)));
    for (int i = 0; i < 6; i++) do_fetch($urandom);
    tick();
    chk("ivalid_idle", inst_valid, 0);

    do_dbg(7'd0);
    do_dbg(7'd68);
    do_dbg(7'd72);
    for (int i = 0; i < 10; i++) do_dbg(7'($urandom_range(0, 31) * 4));

    // Starvation: debug must win exactly once, on the (STARVE_LIMIT+1)th cycle.
    ack_at = -1; acks = 0;
    dbg_req = 1'b1; dbg_addr = '0;
    for (int c = 0; c < 10; c++) begin
      fetch_req = 1'b1; fetch_addr = 32'(4 * (c % 8));
      #1;
      chk("starve_gnt", fetch_gnt, (c != STARVE_LIMIT));
      tick();
      chk("starve_ivalid", inst_valid, (c != STARVE_LIMIT));
      if (dbg_ack) begin
        acks++;
        if (ack_at < 0) ack_at = c + 1;
        chk("starve_rdata", dbg_rdata, word_at(0));
        dbg_req = 1'b0;
      end
    end
    fetch_req = 1'b0;
    chk("starve_ack_cycle", ack_at, STARVE_LIMIT + 1);
    chk("starve_acks", acks, 1);

    pulse_reload();

    // Asynchronous reset in the middle of a load.
    rand_image(3);
    load_image(3, 1'b0);
    ld_valid = 1'b1; ld_data = 8'h77;
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_hold", core_hold, 1);
    chk("mid_rst_ready", ld_ready, 0);
    chk("mid_rst_we", mem_we, 0);
    chk("mid_rst_ovf", load_ovf, 0);
    chk("mid_rst_inst", inst_out, 0);
    chk("mid_rst_rdata", dbg_rdata, 0);
    chk("mid_rst_ivalid", inst_valid, 0);
    ld_valid = 1'b0;
    #3 rst = 1'b1;
    rand_image(4);
    load_image(4, 1'b1);
    chk("post_rst_hold", core_hold, 0);
    do_fetch(32'd0);
    do_fetch(32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
